tsense_monitor: RTL and testbench
=================================

# tsense_monitor

Downstream consumer of the LM07 continuous SPI reader's 8-bit temperature word. Accepts each new reading on a valid strobe, produces a 4-sample moving average, and runs a hysteresis over-temperature alarm state machine on that average. Optionally tracks the peak raw reading. Feeds the board-level alarm LED and display logic.

## Interface

- T_HIGH, 8'sd50: signed alarm-set threshold in °C; the average must be strictly greater than this.
- T_LOW, 8'sd45: signed alarm-clear threshold in °C; the average must be strictly less than this. Must satisfy T_LOW <= T_HIGH.
- TRIP_CNT, 3: number of consecutive averages above T_HIGH required to raise the alarm. Legal range 1..15.

- SYSCLK, input, 1: system clock; all logic is on the rising edge.
- RST, input, 1: reset, asynchronous and active-high.
- DIN, input, 8: latched sensor reading, two's-complement °C.
- DIN_VLD, input, 1: one-cycle strobe; DIN holds a new reading.
- PEAK_CLR, input, 1: synchronous clear of the peak register.
- AVG, output, 8: signed moving average of the last 4 samples.
- AVG_STB, output, 1: one-cycle pulse; AVG has just been updated.
- ALARM, output, 1: over-temperature alarm, level output.
- PEAK, output, 8: signed maximum raw reading since the last clear.

## Operation

- **Sample buffer:** a 4-entry shift buffer plus a 10-bit signed running sum.
  - On each accepted sample: sum <= sum + DIN − oldest entry. Both operands are sign-extended to 10 bits.
  - A 3-bit fill counter saturates at 4.
- **Average:** AVG = sum >>> 2 (arithmetic shift, floor toward −∞), truncated to 8 bits. The result cannot overflow.
- **Warm-up:** AVG_STB stays low until the 4th sample after reset has been accepted. From then on, every accepted sample produces one AVG_STB.
- **Throughput:** DIN_VLD may be asserted on consecutive cycles; every strobe is accepted.
- **FSM states:** IDLE, NORMAL, PEND, ALARM. A 4-bit trip counter is used. The FSM evaluates only on the cycle AVG_STB=1, using the new AVG.
  - IDLE → NORMAL on the first AVG_STB. This same evaluation also applies the NORMAL rules.
  - NORMAL:
    - AVG > T_HIGH: go to PEND with cnt=1.
    - If TRIP_CNT=1, go directly to ALARM instead.
  - PEND:
    - AVG > T_HIGH: cnt+1; on reaching TRIP_CNT, go to ALARM.
    - Otherwise: go to NORMAL and cnt=0.
  - ALARM: AVG < T_LOW → NORMAL, cnt=0. Otherwise stay in ALARM.
- **ALARM output:** ALARM = 1 exactly when state = ALARM (registered).
- **Signed compares:** all comparisons are signed. 8'hFD is −3, which is less than T_LOW.

## Timing

- **Pipeline:**
  - E0: rising edge where DIN_VLD=1. Buffer, sum and fill counter update at E0.
  - E1: AVG and AVG_STB update at E1; AVG_STB is high for the cycle after E1.
  - E2: state, cnt and ALARM update at E2.
- **Alarm latency:** ALARM changes 2 cycles after the accepting edge of the deciding sample.
- **Reset values:**
  - AVG = 8'h00
  - AVG_STB = 0
  - ALARM = 0
  - PEAK = 8'h80
  - State IDLE, cnt = 0, fill = 0, sum = 0, buffer entries 0
- **Reset mid-operation:** all state is discarded immediately. Four fresh samples are required before the next AVG_STB.
- **Sum arithmetic:** wraps only in 10 bits; it is exact for every 4×8-bit signed input.

## Configuration

- Macro `TSENSE_PEAK_HOLD_EN`.
- **Defined:**
  - On an accepted sample, PEAK updates at E0 when DIN > PEAK (signed).
  - PEAK_CLR=1 alone loads 8'h80.
  - PEAK_CLR and DIN_VLD in the same cycle: PEAK loads DIN.
- **Undefined:** no peak register. PEAK is constant 8'h80 and PEAK_CLR is ignored.

## Test plan

- Reset, then samples 20, 22, 24, 26 → AVG_STB appears only after the 4th sample, with AVG=23; no AVG_STB after samples 1–3.
- Four samples −3, −3, −3, −2 → sum −11, AVG=8'hFD (−3). This checks floor rounding.
- Defaults:
  - Six samples of 60 → ALARM rises 2 cycles after the 6th accept.
  - Then samples 47 ×4 → averages 56, 53, 50, 47; ALARM stays 1.
  - Then samples 40 ×2 → averages 45 (ALARM held), then 43 (ALARM falls 2 cycles after that accept).
- Averages 60, 60, 48 starting from NORMAL → no ALARM; cnt back to 0. A following 60, 60, 60 → ALARM.
- Assert RST after 2 samples, mid-stream → AVG=0, ALARM=0; 4 new samples are needed before AVG_STB; samples 4 ×4 give AVG=4.
- With `TSENSE_PEAK_HOLD_EN`:
  - Samples 10, 90, −5 → PEAK=90.
  - PEAK_CLR together with DIN_VLD, DIN=7 → PEAK=7.
  - Without the macro, PEAK stays 8'h80 throughout.

Source files
------------

// File: rtl/tsense_monitor.sv
// tsense_monitor: 4-sample moving average of LM07 temperature words with a hysteresis
// over-temperature alarm FSM. Define TSENSE_PEAK_HOLD_EN to add the raw peak-hold register.
module tsense_monitor #(
    parameter logic signed [7:0] T_HIGH   = 8'sd50,
    parameter logic signed [7:0] T_LOW    = 8'sd45,
    parameter int unsigned       TRIP_CNT = 3
) (
    input  logic       SYSCLK,
    input  logic       RST,
    input  logic [7:0] DIN,
    input  logic       DIN_VLD,
    input  logic       PEAK_CLR,
    output logic [7:0] AVG,
    output logic       AVG_STB,
    output logic       ALARM,
    output logic [7:0] PEAK
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_NORMAL = 2'd1;
    localparam logic [1:0] ST_PEND   = 2'd2;
    localparam logic [1:0] ST_ALARM  = 2'd3;
    localparam logic [3:0] TRIP_LIM  = 4'(TRIP_CNT);

    logic [3:0][7:0]  buf_r;
    logic signed [9:0] sum_r;
    logic signed [9:0] sum_nxt_s;
    logic [2:0]        fill_r;
    logic              avg_pend_r;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nxt_s;
    logic [3:0]        cnt_inc_s;
    logic              above_s;
    logic              below_s;

    // buf_r[3] is the oldest entry; both operands sign-extended so the sum stays exact
    assign sum_nxt_s = sum_r + {{2{DIN[7]}}, DIN} - {{2{buf_r[3][7]}}, buf_r[3]};

    // Sample buffer, running sum and warm-up fill counter (E0)
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            buf_r      <= '0;
            sum_r      <= 10'sd0;
            fill_r     <= 3'd0;
            avg_pend_r <= 1'b0;
        end else begin
            avg_pend_r <= DIN_VLD && (fill_r >= 3'd3);
            if (DIN_VLD) begin
                buf_r  <= {buf_r[2:0], DIN};
                sum_r  <= sum_nxt_s;
                fill_r <= (fill_r == 3'd4) ? 3'd4 : fill_r + 3'd1;
            end
        end
    end

    // Average register and strobe (E1); bits [9:2] are the floor of sum/4
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            AVG     <= 8'h00;
            AVG_STB <= 1'b0;
        end else begin
            AVG_STB <= avg_pend_r;
            if (avg_pend_r) begin
                AVG <= sum_r[9:2];
            end
        end
    end

    assign above_s   = $signed(AVG) > T_HIGH;
    assign below_s   = $signed(AVG) < T_LOW;
    assign cnt_inc_s = cnt_r + 4'd1;

    // Hysteresis next-state logic, evaluated only on a fresh average
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (AVG_STB) begin
            case (state_r)
                ST_IDLE, ST_NORMAL: begin
                    if (above_s) begin
                        cnt_nxt_s   = 4'd1;
                        state_nxt_s = (TRIP_LIM == 4'd1) ? ST_ALARM : ST_PEND;
                    end else begin
                        cnt_nxt_s   = 4'd0;
                        state_nxt_s = ST_NORMAL;
                    end
                end
                ST_PEND: begin
                    if (above_s) begin
                        cnt_nxt_s   = cnt_inc_s;
                        state_nxt_s = (cnt_inc_s >= TRIP_LIM) ? ST_ALARM : ST_PEND;
                    end else begin
                        cnt_nxt_s   = 4'd0;
                        state_nxt_s = ST_NORMAL;
                    end
                end
                ST_ALARM: begin
                    if (below_s) begin
                        cnt_nxt_s   = 4'd0;
                        state_nxt_s = ST_NORMAL;
                    end else begin
                        state_nxt_s = ST_ALARM;
                    end
                end
                default: begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // State, trip counter and alarm output registers (E2)
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            ALARM   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ALARM   <= (state_nxt_s == ST_ALARM);
        end
    end

`ifdef TSENSE_PEAK_HOLD_EN
    // Peak-hold register; a clear coinciding with a sample restarts from that sample
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            PEAK <= 8'h80;
        end else if (DIN_VLD && PEAK_CLR) begin
            PEAK <= DIN;
        end else if (PEAK_CLR) begin
            PEAK <= 8'h80;
        end else if (DIN_VLD && ($signed(DIN) > $signed(PEAK))) begin
            PEAK <= DIN;
        end
    end
`else
    logic peak_clr_unused_s;
    assign peak_clr_unused_s = PEAK_CLR;
    assign PEAK = 8'h80;
`endif

endmodule

// File: tb/tb_tsense_monitor.sv
// Directed self-checking bench for tsense_monitor (default thresholds 50/45, TRIP_CNT 3).
module tb_tsense_monitor;

    logic       SYSCLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DIN = 8'h00;
    logic       DIN_VLD = 1'b0;
    logic       PEAK_CLR = 1'b0;
    logic [7:0] AVG;
    logic       AVG_STB;
    logic       ALARM;
    logic [7:0] PEAK;

    int   n_checks = 0;
    int   n_fail = 0;
    logic alm_prev = 1'b0;
    logic [7:0] peak_exp = 8'h80;

    tsense_monitor dut (
        .SYSCLK  (SYSCLK),
        .RST     (RST),
        .DIN     (DIN),
        .DIN_VLD (DIN_VLD),
        .PEAK_CLR(PEAK_CLR),
        .AVG     (AVG),
        .AVG_STB (AVG_STB),
        .ALARM   (ALARM),
        .PEAK    (PEAK)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One isolated sample: check peak after E0, strobe/average after E1, alarm after E2
    task automatic push(input logic [7:0] v, input logic clr, input logic stb_e,
                        input logic [7:0] avg_e, input logic alm_e);
        @(negedge SYSCLK);
        DIN = v;
        DIN_VLD = 1'b1;
        PEAK_CLR = clr;
`ifdef TSENSE_PEAK_HOLD_EN
        if (clr) peak_exp = v;
        else if ($signed(v) > $signed(peak_exp)) peak_exp = v;
`endif
        @(negedge SYSCLK);
        DIN_VLD = 1'b0;
        PEAK_CLR = 1'b0;
        check_value("peak", PEAK, peak_exp);
        @(negedge SYSCLK);
        check_value("avg_stb", {7'd0, AVG_STB}, {7'd0, stb_e});
        check_value("avg", AVG, avg_e);
        check_value("alarm_before_e2", {7'd0, ALARM}, {7'd0, alm_prev});
        @(negedge SYSCLK);
        check_value("alarm", {7'd0, ALARM}, {7'd0, alm_e});
        check_value("avg_stb_pulse", {7'd0, AVG_STB}, 8'd0);
        alm_prev = alm_e;
    endtask

    task automatic do_reset();
        @(negedge SYSCLK);
        #2 RST = 1'b1;
        #1;
        check_value("rst_avg", AVG, 8'h00);
        check_value("rst_stb", {7'd0, AVG_STB}, 8'd0);
        check_value("rst_alarm", {7'd0, ALARM}, 8'd0);
        check_value("rst_peak", PEAK, 8'h80);
        @(negedge SYSCLK);
        RST = 1'b0;
        alm_prev = 1'b0;
        peak_exp = 8'h80;
    endtask

    logic [7:0] bb_din [4] = '{8'd8, 8'd12, 8'd16, 8'd20};
    logic [7:0] bb_avg [4] = '{8'd5, 8'd7, 8'd10, 8'd14};

    initial begin
        do_reset();

        // Warm-up: no strobe until the 4th sample
        push(8'd20, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'd22, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'd24, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'd26, 1'b0, 1'b1, 8'd23, 1'b0);

        // Negative samples and floor rounding (-11 >>> 2 = -3)
        push(8'hFD, 1'b0, 1'b1, 8'd17, 1'b0);
        push(8'hFD, 1'b0, 1'b1, 8'd11, 1'b0);
        push(8'hFD, 1'b0, 1'b1, 8'd4, 1'b0);
        push(8'hFE, 1'b0, 1'b1, 8'hFD, 1'b0);

        // Alarm raise after three averages above 50
        push(8'd60, 1'b0, 1'b1, 8'd13, 1'b0);
        push(8'd60, 1'b0, 1'b1, 8'd28, 1'b0);
        push(8'd60, 1'b0, 1'b1, 8'd44, 1'b0);
        push(8'd60, 1'b0, 1'b1, 8'd60, 1'b0);
        push(8'd60, 1'b0, 1'b1, 8'd60, 1'b0);
        push(8'd60, 1'b0, 1'b1, 8'd60, 1'b1);

        // Hysteresis hold and release
        push(8'd47, 1'b0, 1'b1, 8'd56, 1'b1);
        push(8'd47, 1'b0, 1'b1, 8'd53, 1'b1);
        push(8'd47, 1'b0, 1'b1, 8'd50, 1'b1);
        push(8'd47, 1'b0, 1'b1, 8'd47, 1'b1);
        push(8'd40, 1'b0, 1'b1, 8'd45, 1'b1);
        push(8'd40, 1'b0, 1'b1, 8'd43, 1'b0);

        // Averages 60, 60, 48 break the run; then 60 x3 trips
        push(8'd113, 1'b0, 1'b1, 8'd60, 1'b0);
        push(8'd47, 1'b0, 1'b1, 8'd60, 1'b0);
        push(8'hF8, 1'b0, 1'b1, 8'd48, 1'b0);
        push(8'd88, 1'b0, 1'b1, 8'd60, 1'b0);
        push(8'd113, 1'b0, 1'b1, 8'd60, 1'b0);
        push(8'd47, 1'b0, 1'b1, 8'd60, 1'b1);

        // Mid-stream reset while the alarm is active
        push(8'd60, 1'b0, 1'b1, 8'd77, 1'b1);
        push(8'd60, 1'b0, 1'b1, 8'd70, 1'b1);
        do_reset();
        push(8'd4, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'd4, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'd4, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'd4, 1'b0, 1'b1, 8'd4, 1'b0);

        // Back-to-back strobes: every one accepted
        for (int i = 0; i < 6; i++) begin
            @(negedge SYSCLK);
            if (i >= 2) begin
                check_value("b2b_stb", {7'd0, AVG_STB}, 8'd1);
                check_value("b2b_avg", AVG, bb_avg[i-2]);
            end
            if (i < 4) begin
                DIN = bb_din[i];
                DIN_VLD = 1'b1;
`ifdef TSENSE_PEAK_HOLD_EN
                if ($signed(bb_din[i]) > $signed(peak_exp)) peak_exp = bb_din[i];
`endif
            end else begin
                DIN_VLD = 1'b0;
            end
        end
        @(negedge SYSCLK);
        check_value("b2b_stb_end", {7'd0, AVG_STB}, 8'd0);
        check_value("b2b_alarm", {7'd0, ALARM}, 8'd0);

        // Threshold boundary: average 50 does not count, 51 does
        push(8'd50, 1'b0, 1'b1, 8'd24, 1'b0);
        push(8'd50, 1'b0, 1'b1, 8'd34, 1'b0);
        push(8'd50, 1'b0, 1'b1, 8'd42, 1'b0);
        push(8'd50, 1'b0, 1'b1, 8'd50, 1'b0);
        push(8'd54, 1'b0, 1'b1, 8'd51, 1'b0);
        push(8'd50, 1'b0, 1'b1, 8'd51, 1'b0);
        push(8'd50, 1'b0, 1'b1, 8'd51, 1'b1);

        // Peak hold (constant 8'h80 when the feature is not built)
        do_reset();
        push(8'd10, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'd90, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'hFB, 1'b0, 1'b0, 8'd0, 1'b0);
        push(8'd7, 1'b1, 1'b1, 8'd25, 1'b0);
        @(negedge SYSCLK);
        PEAK_CLR = 1'b1;
        @(negedge SYSCLK);
        PEAK_CLR = 1'b0;
        peak_exp = 8'h80;
        check_value("peak_clr_alone", PEAK, peak_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
